// File: rtl/fetch_ctrl.sv
// fetch_ctrl: program-counter sequencing controller.
// Chooses the next PC and PC write enable from the run enable, the load-use
// stall, the data-memory stall and the branch redirect. A redirect that
// resolves while memory is stalled is held and applied on the first cycle
// after the stall, together with an IF/ID flush.
//
// Ports:
//   clk_i, rst_n_i      clock, asynchronous active-low reset
//   start_i             run enable; low forces idle
//   pc_cur_i            current PC register value
//   hazard_stall_i      load-use stall
//   mem_stall_i         data-memory stall (freezes the pipeline)
//   branch_taken_i      taken branch/jump resolved this cycle
//   branch_target_i     redirect target
//   pc_next_o           value to load into the PC
//   pc_write_o          PC load enable
//   flush_o             flush IF/ID this cycle
//   pending_o           a redirect is held
//   fetch_count_o       PC writes while running (wraps)
//   stall_count_o       memory-stall cycles (saturates)
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ILEN     = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [31:0] pc_cur_i,
  input  logic        hazard_stall_i,
  input  logic        mem_stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] pc_next_o,
  output logic        pc_write_o,
  output logic        flush_o,
  output logic        pending_o,
  output logic [31:0] fetch_count_o,
  output logic [15:0] stall_count_o
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t      r_state;
  logic        r_pend;
  logic [31:0] r_ptgt;
  logic [31:0] r_fcnt;
  logic [15:0] r_scnt;

  logic        w_active;
  logic [31:0] w_seq;

  assign w_active = (r_state != IDLE);
  assign w_seq    = pc_cur_i + 32'(ILEN);

  // RUN and HOLD share one priority decision; HOLD only records that the
  // stall is in progress, the cycle it ends is decided like any RUN cycle.
  always_comb begin
    pc_next_o  = w_seq;
    pc_write_o = 1'b0;
    flush_o    = 1'b0;
    if (!w_active) begin
      pc_next_o = RESET_PC;
    end else if (mem_stall_i) begin
      pc_write_o = 1'b0;
    end else if (branch_taken_i) begin
      pc_next_o  = branch_target_i;
      pc_write_o = 1'b1;
      flush_o    = 1'b1;
    end else if (r_pend) begin
      pc_next_o  = r_ptgt;
      pc_write_o = 1'b1;
      flush_o    = 1'b1;
    end else if (hazard_stall_i) begin
      pc_write_o = 1'b0;
    end else begin
      pc_write_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_pend  <= 1'b0;
      r_ptgt  <= 32'h0;
      r_fcnt  <= 32'h0;
      r_scnt  <= 16'h0;
    end else begin
      case (r_state)
        IDLE: if (start_i) r_state <= RUN;
        RUN, HOLD: begin
          if (!start_i) begin
            // Leaving run discards any held redirect; counters keep value.
            r_state <= IDLE;
            r_pend  <= 1'b0;
          end else begin
            r_state <= mem_stall_i ? HOLD : RUN;
            if (mem_stall_i) begin
              if (r_scnt != 16'hFFFF) r_scnt <= r_scnt + 16'h1;
              if (branch_taken_i) begin
                r_pend <= 1'b1;
                r_ptgt <= branch_target_i;
              end
            end else if (branch_taken_i || r_pend) begin
              // Either the held target was applied or a live one superseded it.
              r_pend <= 1'b0;
            end
            if (pc_write_o) r_fcnt <= r_fcnt + 32'h1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pending_o     = r_pend;
  assign fetch_count_o = r_fcnt;
  assign stall_count_o = r_scnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] pc_cur;
  logic        hz, ms, bt;
  logic [31:0] btgt;
  logic [31:0] pc_next;
  logic        pc_write, flush, pending;
  logic [31:0] fcnt;
  logic [15:0] scnt;

  int checks = 0;
  int errors = 0;

  fetch_ctrl dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .pc_cur_i(pc_cur),
    .hazard_stall_i(hz), .mem_stall_i(ms), .branch_taken_i(bt),
    .branch_target_i(btgt), .pc_next_o(pc_next), .pc_write_o(pc_write),
    .flush_o(flush), .pending_o(pending), .fetch_count_o(fcnt),
    .stall_count_o(scnt)
  );

  always #5 clk = ~clk;

  // Reference model: running flag, held redirect, counters as plain numbers.
  bit          m_run;
  bit          m_pend;
  logic [31:0] m_tgt;
  longint      m_fc;
  int          m_sc;
  logic [31:0] e_next;
  bit          e_wr, e_fl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_run = 0; m_pend = 0; m_tgt = 0; m_fc = 0; m_sc = 0;
  endfunction

  // Expected combinational outputs from the priority rules.
  function automatic void m_comb();
    e_next = pc_cur + 32'd4; e_wr = 0; e_fl = 0;
    if (!m_run) e_next = 32'h0;
    else if (ms) ;
    else if (bt) begin e_next = btgt; e_wr = 1; e_fl = 1; end
    else if (m_pend) begin e_next = m_tgt; e_wr = 1; e_fl = 1; end
    else if (!hz) e_wr = 1;
  endfunction

  function automatic void m_edge();
    m_comb();
    if (!m_run) m_run = start;
    else if (!start) begin m_run = 0; m_pend = 0; end
    else begin
      if (ms) begin
        if (m_sc < 65535) m_sc++;
        if (bt) begin m_pend = 1; m_tgt = btgt; end
      end else if (bt) m_pend = 0;
      else if (m_pend) m_pend = 0;
      if (e_wr) m_fc = (m_fc + 1) % 64'h1_0000_0000;
    end
  endfunction

  task automatic check_regs(input string tag);
    chk({tag, ".pending"}, {31'h0, pending}, {31'h0, m_pend});
    chk({tag, ".fcnt"}, fcnt, m_fc[31:0]);
    chk({tag, ".scnt"}, {16'h0, scnt}, m_sc);
  endtask

  // One cycle: apply inputs (called just after a negedge), check outputs,
  // clock, check registered state.
  task automatic step(input string tag, input bit s, input logic [31:0] pc,
                      input bit h, input bit m, input bit b, input logic [31:0] t);
    start = s; pc_cur = pc; hz = h; ms = m; bt = b; btgt = t;
    #1;
    m_comb();
    chk({tag, ".write"}, {31'h0, pc_write}, {31'h0, e_wr});
    chk({tag, ".flush"}, {31'h0, flush}, {31'h0, e_fl});
    if (e_wr || !m_run) chk({tag, ".next"}, pc_next, e_next);
    @(posedge clk);
    m_edge();
    #1;
    check_regs(tag);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0; start = 0; pc_cur = 0; hz = 0; ms = 0; bt = 0; btgt = 0;
    m_reset();
    #1;
    chk("rst.next", pc_next, 32'h0);
    chk("rst.write", {31'h0, pc_write}, 32'h0);
    check_regs("rst");
    @(negedge clk); @(negedge clk);
    rst_n = 1;

    // Start: IDLE cycle, then first write of 4.
    step("start.idle", 1, 32'h0, 0, 0, 0, 0);
    start = 1; pc_cur = 0; #1;
    chk("start.next4", pc_next, 32'h4);
    chk("start.wr1", {31'h0, pc_write}, 32'h1);
    step("start.run", 1, 32'h0, 0, 0, 0, 0);
    chk("start.fc1", fcnt, 32'h1);

    // Hazard stall for two cycles.
    step("hz1", 1, 32'h40, 1, 0, 0, 0);
    step("hz2", 1, 32'h40, 1, 0, 0, 0);
    chk("hz.fc", fcnt, 32'h1);
    pc_cur = 32'h40; hz = 0; #1;
    chk("hz.next", pc_next, 32'h44);
    step("hz.end", 1, 32'h40, 0, 0, 0, 0);

    // Branch captured during a 3-cycle memory stall.
    step("ms1", 1, 32'h44, 0, 1, 0, 0);
    step("ms2", 1, 32'h44, 0, 1, 1, 32'h100);
    chk("ms2.pend", {31'h0, pending}, 32'h1);
    step("ms3", 1, 32'h44, 0, 1, 0, 0);
    ms = 0; #1;
    chk("ms.apply.next", pc_next, 32'h100);
    chk("ms.apply.flush", {31'h0, flush}, 32'h1);
    step("ms.apply", 1, 32'h44, 0, 0, 0, 0);
    chk("ms.pend0", {31'h0, pending}, 32'h0);
    chk("ms.sc3", {16'h0, scnt}, 32'h3);
    step("ms.after", 1, 32'h100, 0, 0, 0, 0);

    // Held 0x100 collides with live 0x200 at stall end.
    step("col1", 1, 32'h104, 0, 1, 1, 32'h100);
    bt = 1; btgt = 32'h200; ms = 0; #1;
    chk("col.next", pc_next, 32'h200);
    step("col2", 1, 32'h104, 0, 0, 1, 32'h200);
    chk("col.pend0", {31'h0, pending}, 32'h0);

    // Hazard plus branch applies redirect.
    step("hzbr", 1, 32'h200, 1, 0, 1, 32'h300);

    // Wrap of sequential PC.
    pc_cur = 32'hFFFF_FFFC; bt = 0; hz = 0; #1;
    chk("wrap.next", pc_next, 32'h0);
    step("wrap", 1, 32'hFFFF_FFFC, 0, 0, 0, 0);

    // start low with pending discards it.
    step("sl1", 1, 32'h0, 0, 1, 1, 32'h500);
    step("sl2", 0, 32'h0, 0, 0, 0, 0);
    step("sl3", 1, 32'h0, 0, 0, 0, 0);
    step("sl4", 1, 32'h0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step("rnd", ($urandom_range(0, 19) != 0), $urandom & 32'hFFFF_FFFC,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0), $urandom & 32'hFFFF_FFFC);

    // Reset asynchronously in HOLD with a pending redirect.
    step("rh0", 1, 32'h10, 0, 0, 0, 0);
    step("rh1", 1, 32'h10, 0, 0, 0, 0);
    step("rh2", 1, 32'h10, 0, 1, 1, 32'h800);
    start = 1; ms = 0; bt = 0; #2;
    rst_n = 0; #1;
    m_reset();
    chk("mrst.next", pc_next, 32'h0);
    chk("mrst.write", {31'h0, pc_write}, 32'h0);
    chk("mrst.flush", {31'h0, flush}, 32'h0);
    check_regs("mrst");
    @(negedge clk);
    rst_n = 1;
    step("rel.idle", 1, 32'h0, 0, 0, 0, 0);
    step("rel.run", 1, 32'h0, 0, 0, 0, 0);
    step("rel.run2", 1, 32'h4, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
